// File: rtl/stage_three_mem_if.sv
// stage_three_mem_if: data-memory req/ack bus between the memory stage and data memory.
interface stage_three_mem_if #(
    parameter int ADDR_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic              ack;
    logic [15:0]       rdata;
    logic              err;
    modport master (output req, we, addr, wdata, err, input ack, rdata);
    modport slave  (input req, we, addr, wdata, err, output ack, rdata);
endinterface

// File: rtl/stage_three_mem.sv
// stage_three_mem: pipeline memory stage; issues loads/stores over a req/ack bus,
// stalls upstream while an access is outstanding and registers the writeback result.
module stage_three_mem #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     halt_sys,
    input  logic [1:0]               in_memc,
    input  logic [31:0]              in_alu,
    input  logic [15:0]              in_R1_data,
    input  logic                     in_R0_en,
    input  logic [15:0]              in_instr,
    output logic                     stall_out,
    stage_three_mem_if.master        mem,
    output logic [31:0]              out_data,
    output logic                     out_R0_en,
    output logic [15:0]              out_instr,
    output logic                     out_valid
);
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERROR} state_t;
    state_t        state, next;
    logic [CW-1:0] cnt;
    logic [15:0]   cap;
    logic          is_mem, expired, pass, finish;
    logic [31:0]   result;
    assign is_mem  = in_memc == 2'b01 || in_memc == 2'b10;
    assign expired = cnt == CW'(TIMEOUT - 1);
    assign pass    = state == IDLE && !halt_sys && !is_mem;
    assign finish  = !halt_sys && ((state == ACCESS && mem.ack) || state == DONE);
    // a store (or plain ALU op) forwards the execute result; a load forwards read data
    assign result  = (state == IDLE || mem.we) ? in_alu
                   : {16'h0, state == DONE ? cap : mem.rdata};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end
    always_comb begin
        next      = state;
        stall_out = 1'b0;
        case (state)
            IDLE: begin
                stall_out = is_mem && !halt_sys;
                if (stall_out) next = ACCESS;
            end
            ACCESS: begin
                stall_out = !(mem.ack && !halt_sys);
                if (mem.ack) next = halt_sys ? DONE : IDLE;
                else if (expired) next = ERROR;
            end
            DONE: begin
                stall_out = halt_sys;
                if (!halt_sys) next = IDLE;
            end
            default: stall_out = 1'b1;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem.req   <= 1'b0;
            mem.we    <= 1'b0;
            mem.addr  <= '0;
            mem.wdata <= '0;
            mem.err   <= 1'b0;
            cnt       <= '0;
            cap       <= '0;
            out_data  <= '0;
            out_R0_en <= 1'b0;
            out_instr <= '0;
            out_valid <= 1'b0;
        end else begin
            if (state == IDLE && !halt_sys && is_mem) begin
                mem.req   <= 1'b1;
                mem.we    <= in_memc == 2'b10;
                mem.addr  <= in_alu[ADDR_W-1:0];
                mem.wdata <= in_R1_data;
                cnt       <= '0;
            end
            if (state == ACCESS && mem.ack) mem.req <= 1'b0;
            if (state == ACCESS && mem.ack && halt_sys) cap <= mem.rdata;
            if (state == ACCESS && !mem.ack) begin
                cnt <= cnt + 1'b1;
                if (expired) begin
                    mem.req <= 1'b0;
                    mem.err <= 1'b1;
                end
            end
            if (pass || finish) begin
                out_data  <= result;
                out_R0_en <= in_R0_en;
                out_instr <= in_instr;
                out_valid <= 1'b1;
            end else if ((!halt_sys && (state == IDLE || state == ACCESS)) || next == ERROR) begin
                out_valid <= 1'b0;
                out_R0_en <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stage_three_mem.sv
// tb_stage_three_mem: vector table, hand-written corner sequences and a randomized
// upstream/memory environment checked against an instruction-level scoreboard.
module tb_stage_three_mem;
    logic        clk = 1'b0, rst = 1'b1, halt_sys = 1'b0;
    logic [1:0]  in_memc = 2'b00;
    logic [31:0] in_alu = '0;
    logic [15:0] in_R1_data = '0, in_instr = '0;
    logic        in_R0_en = 1'b0;
    logic        stall_out, out_R0_en, out_valid;
    logic [31:0] out_data;
    logic [15:0] out_instr;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    stage_three_mem_if #(.ADDR_W(16)) bus ();

    stage_three_mem #(.ADDR_W(16), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .halt_sys(halt_sys), .in_memc(in_memc), .in_alu(in_alu),
        .in_R1_data(in_R1_data), .in_R0_en(in_R0_en), .in_instr(in_instr),
        .stall_out(stall_out), .mem(bus), .out_data(out_data), .out_R0_en(out_R0_en),
        .out_instr(out_instr), .out_valid(out_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [1:0] m, input logic [31:0] a, input logic [15:0] r1,
                          input logic r0, input logic [15:0] ins);
        in_memc = m; in_alu = a; in_R1_data = r1; in_R0_en = r0; in_instr = ins;
    endtask

    // Issues one memory op, acks it `lat` cycles after issue; ends on the edge that retires it.
    task automatic run_mem(input logic [1:0] op, input logic [31:0] a, input logic [15:0] r1,
                           input int lat, input logic [15:0] rd,
                           output int stalls, output int pulses, output int cycles);
        int k = 0;
        bit done = 0;
        stalls = 0; pulses = 0;
        set_in(op, a, r1, 1'b1, 16'h7000 | 16'(op));
        do begin
            bus.ack = (k == lat); bus.rdata = rd;
            #1;
            if (stall_out) stalls++;
            if (k == 1) begin
                chk("issue_req", 32'(bus.req), 1);
                chk("issue_addr", 32'(bus.addr), 32'(a[15:0]));
                chk("issue_we", 32'(bus.we), 32'(op == 2'b10));
                chk("issue_wdata", 32'(bus.wdata), 32'(r1));
            end
            done = k > 0 && !stall_out;
            @(negedge clk);
            k++;
            if (out_valid) pulses++;
        end while (!done && k < 40);
        bus.ack = 1'b0;
        cycles = k;
        chk("mem_op_completed", 32'(done), 1);
        chk("mem_op_req_dropped", 32'(bus.req), 0);
        set_in(2'b00, 32'h0, 16'h0, 1'b0, 16'h0);
    endtask

    typedef struct {
        logic [1:0]  memc;
        logic [31:0] alu;
        logic        r0en;
        logic [15:0] instr;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int st, pl, cy, stuck;
        logic [31:0] held;
        logic [1:0]  r_op;
        logic [31:0] r_alu, e_data, h_data;
        logic [15:0] r_r1, r_ins, last_rd, h_instr;
        logic        r_r0, h_valid, h_r0, cons, hlt;
        int          dly;
        bit          acked;
        bus.ack = 1'b0; bus.rdata = '0;
        vecs[0] = '{2'b00, 32'h0001_0005, 1'b1, 16'h1001, 32'h0001_0005};
        vecs[1] = '{2'b11, 32'hDEAD_BEEF, 1'b0, 16'h1002, 32'hDEAD_BEEF};
        vecs[2] = '{2'b00, 32'hFFFF_FFFF, 1'b1, 16'hFFFF, 32'hFFFF_FFFF};
        vecs[3] = '{2'b11, 32'h0000_0000, 1'b1, 16'h0000, 32'h0000_0000};
        #1;
        chk("rst_req", 32'(bus.req), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", out_data, 0);
        chk("rst_stall", 32'(stall_out), 0);
        @(negedge clk); rst = 1'b0;

        foreach (vecs[i]) begin
            set_in(vecs[i].memc, vecs[i].alu, 16'h5A5A, vecs[i].r0en, vecs[i].instr);
            #1 chk("alu_stall", 32'(stall_out), 0);
            @(negedge clk);
            chk("alu_data", out_data, vecs[i].exp_data);
            chk("alu_valid", 32'(out_valid), 1);
            chk("alu_instr", 32'(out_instr), 32'(vecs[i].instr));
            chk("alu_r0en", 32'(out_R0_en), 32'(vecs[i].r0en));
        end

        run_mem(2'b01, 32'h0000_0040, 16'h0, 4, 16'hBEEF, st, pl, cy);
        chk("load_stall_cycles", st, 4);
        chk("load_data", out_data, 32'h0000_BEEF);
        chk("load_pulses", pl, 1);

        run_mem(2'b10, 32'h1234_0010, 16'h1234, 1, 16'hAAAA, st, pl, cy);
        chk("store_cycles", cy, 2);
        chk("store_data", out_data, 32'h1234_0010);
        chk("store_pulses", pl, 1);

        set_in(2'b01, 32'h0000_0080, 16'h0, 1'b1, 16'h0404);
        repeat (16) @(negedge clk);
        chk("to_last_req", 32'(bus.req), 1);
        chk("to_last_err", 32'(bus.err), 0);
        @(negedge clk);
        chk("to_err", 32'(bus.err), 1);
        chk("to_req", 32'(bus.req), 0);
        chk("to_valid", 32'(out_valid), 0);
        repeat (3) @(negedge clk);
        set_in(2'b00, 32'h0, 16'h0, 1'b0, 16'h0);
        #1 chk("to_stall_stuck", 32'(stall_out), 1);
        rst = 1'b1;
        #1;
        chk("to_rst_err", 32'(bus.err), 0);
        chk("to_rst_stall", 32'(stall_out), 0);
        @(negedge clk); rst = 1'b0;

        set_in(2'b00, 32'h0000_1111, 16'h0, 1'b0, 16'h0101);
        @(negedge clk);
        set_in(2'b01, 32'h0000_0050, 16'h0, 1'b1, 16'h0505);
        @(negedge clk);
        held = out_data;
        chk("halt_bubble", 32'(out_valid), 0);
        halt_sys = 1'b1;
        @(negedge clk);
        bus.ack = 1'b1; bus.rdata = 16'hCAFE;
        #1 chk("halt_ack_stall", 32'(stall_out), 1);
        @(negedge clk);
        bus.ack = 1'b0;
        chk("done_req", 32'(bus.req), 0);
        chk("done_frozen", out_data, held);
        #1 chk("done_stall", 32'(stall_out), 1);
        @(negedge clk);
        chk("done_frozen2", out_data, held);
        chk("done_valid", 32'(out_valid), 0);
        halt_sys = 1'b0;
        #1 chk("done_release_stall", 32'(stall_out), 0);
        @(negedge clk);
        chk("done_data", out_data, 32'h0000_CAFE);
        chk("done_out_valid", 32'(out_valid), 1);
        chk("done_instr", 32'(out_instr), 16'h0505);
        set_in(2'b00, 32'h0000_0099, 16'h0, 1'b0, 16'h0909);
        @(negedge clk);
        chk("done_no_double", out_data, 32'h0000_0099);

        set_in(2'b01, 32'h0000_0033, 16'h0, 1'b1, 16'h0606);
        @(negedge clk);
        chk("mid_req", 32'(bus.req), 1);
        #2 rst = 1'b1;
        #1 chk("mid_rst_req", 32'(bus.req), 0);
        halt_sys = 1'b1;
        @(negedge clk); rst = 1'b0;
        bus.ack = 1'b1; bus.rdata = 16'hDEAD;
        @(negedge clk);
        bus.ack = 1'b0;
        chk("stray_valid", 32'(out_valid), 0);
        chk("stray_data", out_data, 0);
        chk("stray_req", 32'(bus.req), 0);
        halt_sys = 1'b0;
        set_in(2'b00, 32'h0000_0055, 16'h0, 1'b0, 16'h0707);
        @(negedge clk);
        chk("after_stray_data", out_data, 32'h0000_0055);

        // randomized upstream that honours stall/halt, and a variable-latency memory
        r_op = 2'($urandom_range(0, 3)); r_alu = $urandom; r_r1 = 16'($urandom);
        r_r0 = 1'($urandom); r_ins = 16'($urandom);
        set_in(r_op, r_alu, r_r1, r_r0, r_ins);
        acked = 0; dly = 0; stuck = 0; last_rd = '0;
        for (int i = 0; i < 1500; i++) begin
            halt_sys = $urandom_range(0, 4) == 0;
            if (!bus.req) begin
                bus.ack = 1'b0; acked = 0; dly = $urandom_range(0, 6);
            end else if (!acked && dly == 0) begin
                bus.ack = 1'b1; bus.rdata = 16'($urandom); last_rd = bus.rdata; acked = 1;
                chk("rnd_addr", 32'(bus.addr), 32'(r_alu[15:0]));
                chk("rnd_we", 32'(bus.we), 32'(r_op == 2'b10));
                chk("rnd_wdata", 32'(bus.wdata), 32'(r_r1));
            end else begin
                bus.ack = 1'b0;
                if (!acked) dly--;
            end
            #1;
            hlt = halt_sys;
            cons = !stall_out && !halt_sys;
            if ((r_op == 2'b00 || r_op == 2'b11) && !halt_sys) chk("rnd_alu_nostall", 32'(stall_out), 0);
            h_data = out_data; h_valid = out_valid; h_instr = out_instr; h_r0 = out_R0_en;
            e_data = (r_op == 2'b01) ? {16'h0, last_rd} : r_alu;
            @(negedge clk);
            if (hlt) begin
                chk("rnd_hold_data", out_data, h_data);
                chk("rnd_hold_valid", 32'(out_valid), 32'(h_valid));
                chk("rnd_hold_instr", 32'(out_instr), 32'(h_instr));
                chk("rnd_hold_r0", 32'(out_R0_en), 32'(h_r0));
            end else begin
                chk("rnd_valid", 32'(out_valid), 32'(cons));
                if (cons) begin
                    chk("rnd_data", out_data, e_data);
                    chk("rnd_instr", 32'(out_instr), 32'(r_ins));
                    chk("rnd_r0", 32'(out_R0_en), 32'(r_r0));
                end
            end
            if (cons) begin
                stuck = 0;
                r_op = 2'($urandom_range(0, 3)); r_alu = $urandom; r_r1 = 16'($urandom);
                r_r0 = 1'($urandom); r_ins = 16'($urandom);
                set_in(r_op, r_alu, r_r1, r_r0, r_ins);
            end else if (++stuck > 40) begin
                chk("rnd_progress", stuck, 40);
                break;
            end
        end
        chk("rnd_no_err", 32'(bus.err), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
